wire_decl_gate: RTL and testbench
=================================

Name: wire_decl_gate

Overview:
- Small combinational logic cell computing an AND-OR function of four single-bit inputs, plus its complement.
- Pure combinational core: dout = (a AND b) OR (c AND d); out_n = NOT dout.
- Wrapped with a clocked observation stage (registered copies and a rising-edge event counter) for use as a glue/status cell in control paths.
- Combinational outputs never depend on clock or reset.

Parameters:
- CNT_W, 8, width of the dout rising-edge event counter.

Ports:
- clk  input  1  system clock; used only by the observation stage.
- reset  input  1  asynchronous, active-high reset; affects only the observation stage.
- a  input  1  first operand of the upper AND term.
- b  input  1  second operand of the upper AND term.
- c  input  1  first operand of the lower AND term.
- d  input  1  second operand of the lower AND term.
- dout  output  1  combinational (a&b)|(c&d).
- out_n  output  1  combinational complement of dout.
- dout_q  output  1  dout registered on rising clk.
- out_n_q  output  1  out_n registered on rising clk.
- rise_cnt  output  CNT_W  count of clk edges where dout_q went 0->1.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Internal nets: and_ab = a&b; and_cd = c&d; dout = and_ab | and_cd; out_n = ~dout.
- dout and out_n are purely combinational, with zero latency and no storage.
- They must settle within the same timestep as any input change, with no glitch-sensitive sequencing assumed.
- They are valid regardless of the clk or reset state, including during reset.
- Truth: dout = 1 iff (a=1 and b=1) or (c=1 and d=1); otherwise 0.
- out_n == ~dout at all times.
- X/Z propagation: follows standard 4-state operator semantics. No X masking is added.
- Reset (reset=1, asynchronous assertion):
  - dout_q = 0.
  - out_n_q = 1, consistent with the complement invariant.
  - rise_cnt = 0.
- Release of reset is synchronous in effect: the first update occurs on the first rising clk with reset=0.
- On each rising clk with reset=0:
  - dout_q <= dout.
  - out_n_q <= out_n.
  - If dout=1 and dout_q=0, rise_cnt <= rise_cnt+1.
- rise_cnt wraps modulo 2^CNT_W (all-ones + 1 -> 0) and never saturates.
- Reset asserted mid-operation immediately clears the registered outputs and counter. Combinational outputs continue to follow the inputs.
- Invariants:
  - out_n_q == ~dout_q at all times outside X conditions.
  - Registered outputs lag the combinational outputs by exactly one clk rising edge.

Decomposition:
- No shared package is required. CNT_W is local.
- One natural sub-module, and_or_inv: pure combinational a,b,c,d -> dout,out_n. The top instantiates it and adds the clocked observation stage.

Test Plan:
- Exhaustive combinational sweep: step {d,c,b,a} from 0 to 15, changing on both clk edges.
  - dout=1 exactly for values 3, 7, 11, 12, 13, 14, 15; dout=0 otherwise.
  - out_n == ~dout on every sample.
- Random inputs: 100 random {a,b,c,d} vectors applied on both clk edges -> dout/out_n match (a&b)|(c&d) and its inverse on every edge, with zero mismatches.
- Reset independence:
  - Hold reset=1 with a=b=1, c=d=0 -> dout=1, out_n=0 immediately.
  - In the same condition, dout_q=0, out_n_q=1, rise_cnt=0.
- Registered lag:
  - Release reset; set c=d=1 before a rising clk -> dout_q=1, out_n_q=0 after that edge, and rise_cnt=1.
  - Holding the inputs leaves rise_cnt at 1.
- Counter wrap with CNT_W=2: toggle dout 0->1 four times, each level held at least one clk -> rise_cnt sequence 1, 2, 3, 0.
- Async reset mid-count: assert reset between clk edges with rise_cnt=2 -> rise_cnt=0 and dout_q=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/wire_decl_gate_pkg.sv
// Shared constants for the wire_decl_gate glue cell.
package wire_decl_gate_pkg;

  // Default width of the dout rising-edge event counter.
  localparam int unsigned CNT_W_DEF = 8;

endpackage : wire_decl_gate_pkg

// File: rtl/wire_decl_gate_and_or_inv.sv
// Pure combinational AND-OR cell with complemented output.
module and_or_inv (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic dout,
  output logic out_n
);

  logic and_ab;
  logic and_cd;

  // AND-OR function and its complement; no storage, zero latency.
  always_comb begin
    and_ab = a & b;
    and_cd = c & d;
    dout   = and_ab | and_cd;
    out_n  = ~dout;
  end

endmodule : and_or_inv

// File: rtl/wire_decl_gate.sv
// AND-OR glue cell with a clocked observation stage: registered copies of the
// combinational outputs and a counter of dout rising edges seen at clk.
module wire_decl_gate
  import wire_decl_gate_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             dout,
  output logic             out_n,
  output logic             dout_q,
  output logic             out_n_q,
  output logic [CNT_W-1:0] rise_cnt
);

  and_or_inv u_core (
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .dout  (dout),
    .out_n (out_n)
  );

  // Observation stage: register outputs and count 0->1 transitions of dout_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q   <= 1'b0;
      out_n_q  <= 1'b1;
      rise_cnt <= '0;
    end else begin
      dout_q  <= dout;
      out_n_q <= out_n;
      if (dout && !dout_q) begin
        rise_cnt <= rise_cnt + 1'b1;
      end
    end
  end

endmodule : wire_decl_gate

// File: tb/tb_wire_decl_gate.sv
// Self-checking bench for wire_decl_gate: two instances (8-bit and 2-bit
// counters) share all inputs and are compared against a behavioural model.
module tb_wire_decl_gate;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

  logic       dout8, out_n8, dout_q8, out_n_q8;
  logic [7:0] rise8;
  logic       dout2, out_n2, dout_q2, out_n_q2;
  logic [1:0] rise2;

  int checks = 0;
  int errors = 0;

  // Truth set of {d,c,b,a} values that make the output high: 3,7,11,12..15.
  localparam logic [15:0] TRUTH = 16'hF888;

  // Behavioural model state.
  logic        m_q   = 1'b0;
  int unsigned m_cnt = 0;
  bit          cmp_en = 1'b0;

  wire_decl_gate #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .dout(dout8), .out_n(out_n8), .dout_q(dout_q8), .out_n_q(out_n_q8),
    .rise_cnt(rise8)
  );

  wire_decl_gate #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .dout(dout2), .out_n(out_n2), .dout_q(dout_q2), .out_n_q(out_n_q2),
    .rise_cnt(rise2)
  );

  always #5 clk = ~clk;

  function automatic logic model_out(input logic ia, ib, ic, id);
    logic [3:0] v;
    v = {id, ic, ib, ia};
    return TRUTH[v];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the observation stage: level register plus event count.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q   <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_q <= model_out(a, b, c, d);
      if (model_out(a, b, c, d) && !m_q) m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dout8",    {31'd0, dout8},    {31'd0, model_out(a, b, c, d)});
      check("out_n8",   {31'd0, out_n8},   {31'd0, ~model_out(a, b, c, d)});
      check("dout2",    {31'd0, dout2},    {31'd0, model_out(a, b, c, d)});
      check("dout_q8",  {31'd0, dout_q8},  {31'd0, m_q});
      check("out_n_q8", {31'd0, out_n_q8}, {31'd0, ~m_q});
      check("dout_q2",  {31'd0, dout_q2},  {31'd0, m_q});
      check("rise8",    {24'd0, rise8},    m_cnt % 256);
      check("rise2",    {30'd0, rise2},    m_cnt % 4);
    end
  end

  // Drive a vector and check the combinational outputs in the same timestep window.
  task automatic apply(input logic [3:0] v, input string tag);
    {d, c, b, a} = v;
    #1;
    check({tag, "_dout"},  {31'd0, dout8},  {31'd0, TRUTH[v]});
    check({tag, "_out_n"}, {31'd0, out_n8}, {31'd0, ~TRUTH[v]});
  endtask

  initial begin
    logic [1:0] wrap_exp [4];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset independence.
    reset = 1'b1;
    a = 1'b1; b = 1'b1; c = 1'b0; d = 1'b0;
    #1;
    cmp_en = 1'b1;
    check("rst_dout",    {31'd0, dout8},    32'd1);
    check("rst_out_n",   {31'd0, out_n8},   32'd0);
    check("rst_dout_q",  {31'd0, dout_q8},  32'd0);
    check("rst_out_n_q", {31'd0, out_n_q8}, 32'd1);
    check("rst_rise8",   {24'd0, rise8},    32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_dout_q", {31'd0, dout_q8}, 32'd0);
    check("rst_hold_rise2",  {30'd0, rise2},   32'd0);

    // Registered lag after release.
    @(negedge clk);
    #2;
    reset = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b1;
    @(posedge clk);
    #1;
    check("lag_dout_q",  {31'd0, dout_q8},  32'd1);
    check("lag_out_n_q", {31'd0, out_n_q8}, 32'd0);
    check("lag_rise8",   {24'd0, rise8},    32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_rise8", {24'd0, rise8}, 32'd1);

    // Counter wrap on the 2-bit instance.
    @(negedge clk);
    #2;
    {d, c, b, a} = 4'd0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      {d, c, b, a} = 4'd12;
      @(posedge clk);
      #1;
      check("wrap_rise2", {30'd0, rise2}, {30'd0, wrap_exp[k]});
      @(negedge clk);
      #2;
      {d, c, b, a} = 4'd0;
      @(posedge clk);
    end
    #1;
    check("wrap_rise8", {24'd0, rise8}, 32'd4);

    // Async reset mid-count: two more events bring the 2-bit counter to 2.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #2;
      {d, c, b, a} = 4'd3;
      @(posedge clk);
      @(negedge clk);
      #2;
      {d, c, b, a} = 4'd0;
      @(posedge clk);
    end
    #1;
    check("pre_rst_rise2", {30'd0, rise2}, 32'd2);
    @(negedge clk);
    #2;
    {d, c, b, a} = 4'd3;
    reset = 1'b1;
    #1;
    check("async_rise2",  {30'd0, rise2},   32'd0);
    check("async_rise8",  {24'd0, rise8},   32'd0);
    check("async_dout_q", {31'd0, dout_q2}, 32'd0);
    check("async_dout",   {31'd0, dout2},   32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Exhaustive sweep, one vector per clock edge.
    for (int v = 0; v < 16; v++) begin
      if (v % 2 == 0) @(posedge clk); else @(negedge clk);
      #2;
      apply(4'(v), "sweep");
    end

    // Random vectors on both edges.
    for (int n = 0; n < 100; n++) begin
      if (n % 2 == 0) @(posedge clk); else @(negedge clk);
      #2;
      apply(4'($urandom_range(0, 15)), "rand");
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wire_decl_gate
